handshake_tx: RTL and testbench

HANDSHAKE_TX -- requirements
Module: handshake_tx

---
 rtl/handshake_tx.sv | 99 +++++++++
 tb/tb_handshake_tx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/handshake_tx.sv
// Valid/ready transmitter with a DEPTH-entry staging FIFO and a registered output stage.
// Optional transfer counter port xfer_count is built when HS_TX_COUNT_EN is defined.
module handshake_tx #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  output logic                       full,
  output logic                       valid,
  output logic [WIDTH-1:0]           data_out,
  input  logic                       ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       idle
`ifdef HS_TX_COUNT_EN
  ,
  output logic [7:0]                 xfer_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {S_EMPTY = 1'b0, S_PRESENT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic [WIDTH-1:0]  data_q;

  logic xfer, load, fifo_nonempty, fifo_rd, bypass, fifo_wr;

  assign fifo_nonempty = (level_q != '0);
  assign full          = (level_q == LW'(DEPTH));
  assign xfer          = valid & ready;
  assign load          = (state_q == S_EMPTY) | xfer;
  assign fifo_rd       = load & fifo_nonempty;
  assign bypass        = load & ~fifo_nonempty & push;
  // Full is judged on the registered level, so a same-cycle read never rescues a push.
  assign fifo_wr       = push & ~bypass & ~full;
  assign level_d       = level_q + LW'(fifo_wr) - LW'(fifo_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY:   if (fifo_rd || bypass) state_d = S_PRESENT;
      S_PRESENT: if (xfer && !fifo_rd && !bypass) state_d = S_EMPTY;
      default:   state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    valid = (state_q == S_PRESENT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      data_q   <= '0;
    end else begin
      level_q <= level_d;
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (fifo_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        data_q   <= mem[rd_ptr_q];
      end else if (bypass) begin
        data_q   <= push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr_q] <= push_data;
  end

  assign data_out = data_q;
  assign level    = level_q;
  assign idle     = ~valid & ~fifo_nonempty;

`ifdef HS_TX_COUNT_EN
  logic [7:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt_q <= '0;
    else if (xfer) cnt_q <= cnt_q + 8'd1;
  end
  assign xfer_count = cnt_q;
`endif

endmodule

// File: tb/tb_handshake_tx.sv
// Self-checking bench for handshake_tx: directed scenarios plus random traffic vs a queue model.
// Build with and without HS_TX_COUNT_EN.
module tb_handshake_tx;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    push = 1'b0;
  logic [WIDTH-1:0]        push_data = '0;
  logic                    ready = 1'b0;
  logic                    full, valid, idle;
  logic [WIDTH-1:0]        data_out;
  logic [$clog2(DEPTH):0]  level;
`ifdef HS_TX_COUNT_EN
  logic [7:0]              xfer_count;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // reference model: pending words, the offered word, and a transfer tally
  logic [WIDTH-1:0] m_q[$];
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  int               m_cnt = 0;

  handshake_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data),
    .full(full), .valid(valid), .data_out(data_out), .ready(ready),
    .level(level), .idle(idle)
`ifdef HS_TX_COUNT_EN
    , .xfer_count(xfer_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_cnt   = 0;
  endtask

  task automatic model_edge(input logic p, input logic [WIDTH-1:0] d, input logic r);
    bit was_full, taken;
    was_full = (m_q.size() == DEPTH);
    taken = 1'b0;
    if (m_valid && r) m_cnt++;
    if (!m_valid || r) begin
      if (m_q.size() > 0) begin
        m_data = m_q.pop_front();
        m_valid = 1'b1;
      end else if (p) begin
        m_data = d;
        m_valid = 1'b1;
        taken = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (p && !taken && !was_full) m_q.push_back(d);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
    if (m_valid) chk({tag, ".data"}, 32'(data_out), 32'(m_data));
    chk({tag, ".level"}, 32'(level), 32'(m_q.size()));
    chk({tag, ".full"}, 32'(full), 32'(m_q.size() == DEPTH));
    chk({tag, ".idle"}, 32'(idle), 32'(!m_valid && m_q.size() == 0));
`ifdef HS_TX_COUNT_EN
    chk({tag, ".cnt"}, 32'(xfer_count), 32'(m_cnt % 256));
`endif
  endtask

  // drive after a falling edge, advance one rising edge, compare at the next falling edge
  task automatic step(input logic p, input logic [WIDTH-1:0] d, input logic r, input string tag);
    push = p; push_data = d; ready = r;
    @(posedge clk);
    model_edge(p, d, r);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    push = 1'b0; ready = 1'b0;
    model_reset();
    #1;
    chk("rst.valid", 32'(valid), 0);
    chk("rst.data", 32'(data_out), 0);
    chk("rst.level", 32'(level), 0);
    chk("rst.full", 32'(full), 0);
    chk("rst.idle", 32'(idle), 1);
`ifdef HS_TX_COUNT_EN
    chk("rst.cnt", 32'(xfer_count), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // bypass
    step(1'b1, 4'hA, 1'b1, "byp1");
    chk("byp.data", 32'(data_out), 32'hA);
    chk("byp.valid1", 32'(valid), 1);
    step(1'b0, 4'h0, 1'b1, "byp2");
    chk("byp.valid0", 32'(valid), 0);

    // backpressure
    for (int i = 1; i <= 5; i++) step(1'b1, 4'(i), 1'b0, "bp");
    chk("bp.data", 32'(data_out), 32'h1);
    chk("bp.level", 32'(level), 4);
    chk("bp.full", 32'(full), 1);
    step(1'b1, 4'h6, 1'b0, "bp6");
    chk("bp6.level", 32'(level), 4);

    // drain in order
    for (int i = 1; i <= 5; i++) begin
      chk("drain.data", 32'(data_out), 32'(i));
      chk("drain.valid", 32'(valid), 1);
      step(1'b0, 4'h0, 1'b1, "drain");
    end
    chk("drain.end_valid", 32'(valid), 0);
    chk("drain.end_level", 32'(level), 0);
    chk("drain.end_idle", 32'(idle), 1);

    // simultaneous transfer and push while full
    for (int i = 1; i <= 5; i++) step(1'b1, 4'(i), 1'b0, "fill");
    chk("sim.pre_level", 32'(level), 4);
    step(1'b1, 4'h7, 1'b1, "sim");
    chk("sim.level", 32'(level), 3);
    chk("sim.data", 32'(data_out), 32'h2);

    // reset mid-stream with level=3, valid=1
    chk("mid.pre_valid", 32'(valid), 1);
    do_reset();
    step(1'b1, 4'h9, 1'b0, "post_rst");
    chk("post.data", 32'(data_out), 32'h9);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b1, "post_drain");
    chk("post.idle", 32'(idle), 1);

`ifdef HS_TX_COUNT_EN
    do_reset();
    for (int i = 0; i < 256; i++) step(1'b1, 4'(i), 1'b1, "cnt_run");
    step(1'b0, 4'h0, 1'b1, "cnt_last");
    chk("cnt.256", 32'(xfer_count), 0);
    step(1'b1, 4'h3, 1'b0, "cnt_load");
    step(1'b0, 4'h0, 1'b1, "cnt_257");
    chk("cnt.257", 32'(xfer_count), 1);
`endif

    // random traffic with phases of varying push/ready density
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int pp, rp;
      pp = ((i / 200) % 3 == 0) ? 80 : ((i / 200) % 3 == 1) ? 30 : 55;
      rp = ((i / 150) % 3 == 0) ? 25 : ((i / 150) % 3 == 1) ? 90 : 50;
      step(($urandom_range(99) < pp), 4'($urandom), ($urandom_range(99) < rp), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
